keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the seven-segment display driver. That driver strobes digit anodes and drives segment cathodes outward; this block strobes keypad columns and reads rows back in.
- Scans a 4x4 matrix keypad (Pmod KYPD layout), synchronises and debounces the row returns, and rejects multi-key (ghosting) patterns.
- Delivers each new key press as a 4-bit hex code over a valid/ready handshake. Typical consumer: logic that loads the display value.

Parameters:
- SCAN_DIV, 100000: clock cycles per column strobe period (1 ms at 100 MHz). Minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full sweeps required before the stable key state changes. Minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Synchronous, active-low.
- col_n  output  4  column strobes, active-low, exactly one low at a time.
- row_n  input  4  row returns, active-low (pulled up externally), asynchronous.
- key_code  output  4  hex code of the accepted key.
- key_valid  output  1  key_code holds an unconsumed press event.
- key_ready  input  1  consumer accepts the event when high together with key_valid.
- key_held  output  1  debounced state is "one key down".
- overrun  output  1  one-cycle pulse when a press event is dropped.

Behaviour:
- Reset (rst_n low at a clk edge), effective next edge; values:
  - col_n=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0.
  - Divider, column index, debounce count, snapshot and synchroniser all cleared.
  - prev_cand=NONE, stable=NONE.
  - Reset mid-operation discards any pending event and partial sweep.
- Synchroniser: row_n passes through a 2-flop synchroniser, reset value 4'b1111.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronised rows are captured into the snapshot bits for the current column. On the next edge the column index advances 0->1->2->3->0 and col_n rotates its low bit.
  - One sweep = 4*SCAN_DIV cycles. The sweep completes at the column-3 sample.
- Key map (row r, col c), both 0-based, col 0 = col_n[0], row 0 = row_n[0]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Candidate at sweep end:
  - Exactly one snapshot bit pressed -> that key's code.
  - Zero bits or two or more bits -> NONE.
- Debounce (evaluated at sweep end):
  - cand==prev_cand: cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: prev_cand<=cand, cnt<=1.
  - When the updated cnt equals DEBOUNCE_SCANS and prev_cand!=stable: stable<=prev_cand.
- Stable-state FSM:
  - States RELEASED (stable=NONE) and PRESSED (stable=key).
  - RELEASED->PRESSED: emit event.
  - PRESSED->PRESSED with a different key (direct roll without debounced NONE): emit event.
  - PRESSED->RELEASED: no event.
  - key_held = (state==PRESSED), registered, updates on the same edge as stable.
- Event/handshake:
  - An event loads key_code and sets key_valid on the edge after sweep end.
  - key_valid stays high and key_code stays frozen until a cycle with key_valid&key_ready; key_valid deasserts the next edge.
  - key_ready is ignored while key_valid=0.
- Boundary cases:
  - Event arrives while key_valid=1 and key_ready=0: event dropped, key_code unchanged, overrun=1 for exactly one cycle.
  - Event arrives in the same cycle as an acceptance: new code loaded, key_valid stays 1, no overrun.
  - Key held indefinitely: one event only, no auto-repeat.
  - cnt saturation prevents wrap during long holds.
- Widths: divider uses $clog2(SCAN_DIV) bits; debounce count uses $clog2(DEBOUNCE_SCANS+1) bits.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2. Cycle 0 = first edge with rst_n high.
- Reset/rotation: hold rst_n low, then release -> col_n=1110, key_valid=0. col_n reads 1101 from cycle 4, 1011 from 8, 0111 from 12, 1110 from 16.
- Single press: short row1/col2 (key 6) from reset release, key_ready=0 -> key_valid=1, key_code=4'h6, key_held=1 from cycle 32. Both remain stable while ready is low. Pulse key_ready for 1 cycle -> key_valid=0 the next cycle.
- Bounce: toggle key 5 every 8 cycles for 3 sweeps, then hold -> no event during toggling. Exactly one event with code 4'h5, issued 2 full sweeps after toggling stops.
- Ghosting: press keys 1 and 9 together and hold -> key_valid stays 0, key_held=0. Release 9 -> event with code 4'h1 after 2 sweeps.
- Overrun: accept nothing after key A is reported; release, debounce, then press key D -> overrun high exactly 1 cycle, key_code stays 4'hA. Repeat with key_ready=1 on the event edge -> code 4'hD loaded, no overrun.
- Reset mid-operation: assert rst_n low with key_valid=1 for one edge -> all outputs return to reset values next cycle. The still-held key re-reports after 2 sweeps.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad scanner with row synchronisation, sweep-based
//            debounce, multi-key rejection and a valid/ready key-event output.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_DB_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [4:0]       c_NONE    = 5'h10;

    typedef enum logic [0:0] {
        S_RELEASED = 1'b0,
        S_PRESSED  = 1'b1
    } state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [DIV_W-1:0] r_div;
    logic             r_adv;
    logic [1:0]       r_col;
    logic [3:0]       r_col_n;
    logic [15:0]      r_snap;

    logic [4:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_stable;
    state_t           r_state;
    logic             r_evt;
    logic [3:0]       r_evt_code;
    logic [3:0]       r_code;
    logic             r_valid;
    logic             r_ovr;

    logic             w_sample_now;
    logic             w_sweep_end;
    logic [15:0]      w_snap_next;
    logic [4:0]       w_hits;
    logic [3:0]       w_hit_idx;
    logic [4:0]       w_cand;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_promote;

    // Snapshot bit index is {col, row}; value 1 means the key reads pressed.
    function automatic logic [3:0] f_keymap(input logic [3:0] idx);
        case (idx)
            4'h0: f_keymap = 4'h1;  4'h1: f_keymap = 4'h4;
            4'h2: f_keymap = 4'h7;  4'h3: f_keymap = 4'h0;
            4'h4: f_keymap = 4'h2;  4'h5: f_keymap = 4'h5;
            4'h6: f_keymap = 4'h8;  4'h7: f_keymap = 4'hF;
            4'h8: f_keymap = 4'h3;  4'h9: f_keymap = 4'h6;
            4'hA: f_keymap = 4'h9;  4'hB: f_keymap = 4'hE;
            4'hC: f_keymap = 4'hA;  4'hD: f_keymap = 4'hB;
            4'hE: f_keymap = 4'hC;  default: f_keymap = 4'hD;
        endcase
    endfunction

    assign w_sample_now = (r_div == c_DIV_MAX);
    assign w_sweep_end  = w_sample_now && (r_col == 2'd3);

    // The column-3 sample is merged in so the candidate is ready on the sweep-end edge.
    always_comb begin
        w_snap_next = r_snap;
        w_snap_next[{r_col, 2'b00} +: 4] = ~r_sync2;
    end

    always_comb begin
        w_hits    = 5'd0;
        w_hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_snap_next[i]) begin
                w_hits    = w_hits + 5'd1;
                w_hit_idx = 4'(i);
            end
        end
    end

    assign w_cand     = (w_hits == 5'd1) ? {1'b0, f_keymap(w_hit_idx)} : c_NONE;
    assign w_cnt_next = (w_cand != r_prev) ? c_CNT_ONE :
                        (r_cnt == c_DB_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
    assign w_promote  = (w_cnt_next == c_DB_MAX) && (w_cand != r_stable);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_div   <= '0;
            r_adv   <= 1'b0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
            r_snap  <= '0;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
            r_adv   <= w_sample_now;
            if (w_sample_now) begin
                r_div  <= '0;
                r_snap <= w_snap_next;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (r_adv) begin
                r_col   <= r_col + 2'd1;
                r_col_n <= {r_col_n[2:0], r_col_n[3]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev     <= c_NONE;
            r_cnt      <= '0;
            r_stable   <= c_NONE;
            r_state    <= S_RELEASED;
            r_evt      <= 1'b0;
            r_evt_code <= 4'h0;
            r_code     <= 4'h0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_evt <= 1'b0;
            r_ovr <= 1'b0;
            if (w_sweep_end) begin
                r_prev <= w_cand;
                r_cnt  <= w_cnt_next;
                if (w_promote) begin
                    r_stable <= w_cand;
                    if (w_cand == c_NONE) begin
                        r_state <= S_RELEASED;
                    end else begin
                        // Any promotion to a real key (fresh press or direct roll) is an event.
                        r_state    <= S_PRESSED;
                        r_evt      <= 1'b1;
                        r_evt_code <= w_cand[3:0];
                    end
                end
            end
            if (r_evt) begin
                if (!r_valid || key_ready) begin
                    r_code  <= r_evt_code;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && key_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign col_n     = r_col_n;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = (r_state == S_PRESSED);
    assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed bench for keypad_scanner with a cycle-level keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        key_ready = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overrun;

    // Pressed-key mask, bit index = row*4 + col.
    logic [15:0] keys = '0;
    int          total = 0;
    int          bad   = 0;
    int          ecount = 0;
    int          keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] kbit(input int hexv);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++)
            if (keymap[i] == hexv) m[i] = 1'b1;
        return m;
    endfunction

    // Model state: keys seen by the row synchroniser, per-key snapshot, debounce.
    int          m_e;
    logic [15:0] m_d1, m_d2, m_snap;
    int          m_prev, m_cnt, m_stable, m_pcode, m_code;
    bit          m_pend, m_valid, m_ovr;

    always @(posedge clk) begin
        logic        s_rst, s_rdy;
        logic [15:0] s_keys;
        logic [3:0]  one, exp_col;
        int          c, n, idx, cand;
        s_rst  = rst_n;
        s_rdy  = key_ready;
        s_keys = keys;
        #1;
        if (!s_rst) begin
            m_e = -1; m_d1 = '0; m_d2 = '0; m_snap = '0;
            m_prev = -1; m_cnt = 0; m_stable = -1; m_pcode = 0; m_code = 0;
            m_pend = 0; m_valid = 0; m_ovr = 0;
        end else begin
            m_e++;
            m_ovr = 0;
            if (m_pend) begin
                if (!m_valid || s_rdy) begin
                    m_code  = m_pcode;
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && s_rdy) begin
                m_valid = 0;
            end
            m_pend = 0;
            if (m_e % SCAN_DIV == SCAN_DIV - 1) begin
                c = (m_e / SCAN_DIV) % 4;
                for (int r = 0; r < 4; r++) m_snap[r*4+c] = m_d2[r*4+c];
                if (c == 3) begin
                    n = 0; idx = 0;
                    for (int i = 0; i < 16; i++)
                        if (m_snap[i]) begin n++; idx = i; end
                    cand = (n == 1) ? keymap[idx] : -1;
                    if (cand == m_prev) begin
                        if (m_cnt < DEBOUNCE_SCANS) m_cnt++;
                    end else begin
                        m_prev = cand;
                        m_cnt  = 1;
                    end
                    if (m_cnt == DEBOUNCE_SCANS && m_prev != m_stable) begin
                        m_stable = m_prev;
                        if (m_stable >= 0) begin
                            m_pend  = 1;
                            m_pcode = m_stable;
                        end
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = s_keys;
        end
        if (m_e < 0) exp_col = 4'b1110;
        else begin
            one     = 4'b0001 << ((m_e / SCAN_DIV) % 4);
            exp_col = ~one;
        end
        check("model col_n",     col_n,     exp_col);
        check("model key_valid", key_valid, m_valid);
        check("model key_code",  key_code,  m_code);
        check("model key_held",  key_held,  (m_stable >= 0) ? 1 : 0);
        check("model overrun",   overrun,   m_ovr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic wait_to(input int n);
        while (ecount < n) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " col_n"},     col_n,     4'b1110);
        check({tag, " key_valid"}, key_valid, 0);
        check({tag, " key_code"},  key_code,  0);
        check({tag, " key_held"},  key_held,  0);
        check({tag, " overrun"},   overrun,   0);
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = kbit(6);
        repeat (3) tick();
        check_reset_outputs("reset");

        rst_n  = 1'b1;
        ecount = -1;
        wait_to(0);  check("rot c0",  col_n, 4'b1110);
        wait_to(3);  check("rot c3",  col_n, 4'b1110);
        wait_to(4);  check("rot c4",  col_n, 4'b1101);
        wait_to(8);  check("rot c8",  col_n, 4'b1011);
        wait_to(12); check("rot c12", col_n, 4'b0111);
        wait_to(16); check("rot c16", col_n, 4'b1110);

        wait_to(31); check("k6 valid c31", key_valid, 0);
        wait_to(32);
        check("k6 valid c32", key_valid, 1);
        check("k6 code c32",  key_code,  4'h6);
        check("k6 held c32",  key_held,  1);
        wait_to(40);
        check("k6 valid hold", key_valid, 1);
        check("k6 code hold",  key_code,  4'h6);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("k6 accepted", key_valid, 0);
        keys = '0;

        // Bounce on key 5, phase chosen so every sweep samples it released.
        wait_to(103);
        keys = kbit(5);
        for (int i = 1; i <= 6; i++) begin
            wait_to(103 + 8*i);
            keys = (i % 2 == 1) ? 16'h0000 : kbit(5);
        end
        wait_to(191); check("k5 valid c191", key_valid, 0);
        wait_to(192);
        check("k5 valid c192", key_valid, 1);
        check("k5 code c192",  key_code,  4'h5);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("k5 accepted", key_valid, 0);
        keys = '0;

        wait_to(239);
        keys = kbit(1) | kbit(9);
        wait_to(271);
        check("ghost valid", key_valid, 0);
        check("ghost held",  key_held,  0);
        keys = kbit(1);
        wait_to(303); check("k1 valid c303", key_valid, 0);
        wait_to(304);
        check("k1 valid c304", key_valid, 1);
        check("k1 code c304",  key_code,  4'h1);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        keys = '0;

        wait_to(351);
        keys = kbit(10);
        wait_to(383); check("kA valid c383", key_valid, 0);
        wait_to(384);
        check("kA valid c384", key_valid, 1);
        check("kA code c384",  key_code,  4'hA);
        keys = '0;
        wait_to(415);
        keys = kbit(13);
        wait_to(447); check("ovr c447", overrun, 0);
        wait_to(448);
        check("ovr c448",       overrun,   1);
        check("ovr code c448",  key_code,  4'hA);
        check("ovr valid c448", key_valid, 1);
        wait_to(449);
        check("ovr c449",      overrun,  0);
        check("ovr code c449", key_code, 4'hA);
        keys = '0;

        wait_to(479);
        keys = kbit(13);
        wait_to(511);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("kD code c512",  key_code,  4'hD);
        check("kD valid c512", key_valid, 1);
        check("kD ovr c512",   overrun,   0);
        tick();
        check("kD ovr c513", overrun, 0);

        wait_to(520);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst_n  = 1'b1;
        ecount = -1;
        wait_to(31); check("rerep valid c31", key_valid, 0);
        wait_to(32);
        check("rerep valid c32", key_valid, 1);
        check("rerep code c32",  key_code,  4'hD);
        check("rerep held c32",  key_held,  1);
        wait_to(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
